fetch_unit: RTL and testbench

Instruction-fetch stage for the 5-stage pipelined processor. It sits directly upstream of the IF/ID pipeline register, which is the stage-1 to stage-2 register. It owns the program counter and issues word reads to instruction memory over a req/ack handshake that tolerates variable latency. Fetched {pc_plus4, instruction} pairs are buffered in a 2-entry prefetch queue, so decode stalls and branch redirects from the MEM stage are absorbed without losing or duplicating instructions.

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_queue.sv | 65 ++++++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and sizing for the instruction-fetch stage and its prefetch queue.
package fetch_unit_pkg;

  localparam int XLEN        = 32;
  localparam int QUEUE_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small circular prefetch FIFO holding {pc_plus4, instr} entries between fetch and IF/ID.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH = $bits(fetch_entry_t),
  parameter int DEPTH = QUEUE_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  input  logic                           flush,
  output logic [WIDTH-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the consumer gates head with count != 0.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

  always @(posedge clk) begin
    if (!rst) assert (!(push && count == CNT_W'(DEPTH)));
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks req/ack to instruction memory and
// feeds IF/ID through a 2-entry prefetch queue, absorbing stalls and MEM-stage redirects.
//
// state   | meaning
// IDLE    | just out of reset, no request issued
// REQ     | fetching at fetch_pc while the queue has room
// DISCARD | old request still outstanding after a redirect; its data is dropped
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                   WORD_SIZE = 32,
  parameter int                   ADDR_BITS = 8,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 stall,
  output logic                 imem_req,
  output logic [ADDR_BITS-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic [WORD_SIZE-1:0] imem_rdata,
  output logic                 if_valid,
  output logic [WORD_SIZE-1:0] if_instr,
  output logic [WORD_SIZE-1:0] if_pc_plus4,
  output logic [WORD_SIZE-1:0] prog_count
);

  localparam int ENTRY_W = 2 * WORD_SIZE;
  localparam int CNT_W   = $clog2(QUEUE_DEPTH + 1);

  fetch_state_t         state_q;
  fetch_state_t         state_d;
  logic [WORD_SIZE-1:0] fetch_pc_q;
  logic [WORD_SIZE-1:0] fetch_pc_d;
  logic [WORD_SIZE-1:0] pc_plus4;
  logic [ADDR_BITS-1:0] pc_addr;
  logic [ADDR_BITS-1:0] req_addr_q;
  logic [CNT_W-1:0]     count;
  logic [ENTRY_W-1:0]   head;
  logic [ENTRY_W-1:0]   push_data;
  logic                 redirect;
  logic                 push;
  logic                 pop;
  logic                 unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  assign pc_plus4  = fetch_pc_q + WORD_SIZE'(4);
  assign pc_addr   = fetch_pc_q[ADDR_BITS+1:2];
  assign redirect  = redirect_valid && (state_q != IDLE);

  // Request depends only on registered state, never on stall or redirect.
  assign imem_req  = (state_q == DISCARD) ||
                     ((state_q == REQ) && (count < CNT_W'(QUEUE_DEPTH)));
  assign imem_addr = (state_q == DISCARD) ? req_addr_q : pc_addr;

  assign push      = (state_q == REQ) && imem_req && imem_ack && !redirect;
  assign pop       = if_valid && !stall && !redirect;
  assign push_data = {pc_plus4, imem_rdata};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = REQ;
      REQ:     if (redirect && imem_req && !imem_ack) state_d = DISCARD;
      DISCARD: if (imem_ack) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect)  fetch_pc_d = {redirect_pc[WORD_SIZE-1:2], 2'b00};
    else if (push) fetch_pc_d = pc_plus4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      // Tracks the live address so DISCARD can hold the one already on the bus.
      if (state_q == REQ) req_addr_q <= pc_addr;
    end
  end

  fetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count)
  );

  assign if_valid    = (count != '0);
  assign if_instr    = if_valid ? head[WORD_SIZE-1:0] : '0;
  assign if_pc_plus4 = if_valid ? head[ENTRY_W-1:WORD_SIZE] : '0;
  assign prog_count  = fetch_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency memory model and an in-order scoreboard.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic [31:0] prog_count;

  int   errors = 0;
  int   checks = 0;
  int   mem_lat = 0;
  int   lat_cnt = 0;
  logic force_ack = 1'b0;
  int   n;

  fetch_entry_t exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [7:0] a);
    return {24'hC0DE5A, a};
  endfunction

  assign imem_rdata = instr_of(imem_addr);
  assign imem_ack   = force_ack || (imem_req && (lat_cnt == mem_lat));

  always @(posedge clk or posedge rst) begin
    if (rst)                       lat_cnt <= 0;
    else if (imem_req && !imem_ack) lat_cnt <= lat_cnt + 1;
    else                           lat_cnt <= 0;
  end

  fetch_unit #(.WORD_SIZE(32), .ADDR_BITS(8), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc_plus4    (if_pc_plus4),
    .prog_count     (prog_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_stream(input logic [31:0] start);
    fetch_entry_t e;
    logic [31:0]  p;
    p = {start[31:2], 2'b00};
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      e.pc_plus4 = p + 32'd4;
      e.instr    = instr_of(p[9:2]);
      exp_q.push_back(e);
      p = p + 32'd4;
    end
  endtask

  // One clock: compare any pop against the scoreboard, reload it on a redirect.
  task automatic tick();
    fetch_entry_t e;
    @(negedge clk);
    if (if_valid && !stall && !redirect_valid && !rst) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc_plus4", if_pc_plus4, e.pc_plus4);
        chk("sb_instr", if_instr, e.instr);
      end
    end
    if (redirect_valid && !rst) load_stream(redirect_pc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_pc_plus4", if_pc_plus4, 32'd0);
    chk("rst_prog_count", prog_count, 32'd0);
    load_stream(32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("idle_no_req", 32'(imem_req), 32'd0);
    tick();
    chk("first_req", 32'(imem_req), 32'd1);

    // zero-wait streaming from RESET_PC
    for (int i = 0; i < 5; i++) begin
      chk("seq_addr", 32'(imem_addr), 32'(i));
      if (i > 0) chk("seq_pc_plus4", if_pc_plus4, 32'(4 * i));
      tick();
    end

    // decode stall: queue fills and requests stop
    stall = 1'b1;
    repeat (5) tick();
    chk("stall_req", 32'(imem_req), 32'd0);
    chk("stall_count", 32'(dut.count), 32'd2);
    chk("stall_pc", prog_count, 32'd24);
    chk("stall_head", if_pc_plus4, 32'd20);
    stall = 1'b0;
    repeat (6) tick();

    // redirect while a slow request is outstanding
    mem_lat = 2;
    n = 0;
    while (!(imem_req && lat_cnt == 0) && n < 20) begin
      tick();
      n++;
    end
    chk("t3_wait_req", 32'(n < 20), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("t3_state_discard", 32'(dut.state_q), 32'(DISCARD));
    chk("t3_flushed", 32'(if_valid), 32'd0);
    tick();
    tick();
    chk("t3_state_req", 32'(dut.state_q), 32'(REQ));
    chk("t3_no_old_data", 32'(if_valid), 32'd0);
    chk("t3_target_addr", 32'(imem_addr), 32'h10);
    n = 0;
    while (!if_valid && n < 10) begin
      tick();
      n++;
    end
    chk("t3_first_pc_plus4", if_pc_plus4, 32'h44);

    // redirect coinciding with ack and pop
    mem_lat = 0;
    n = 0;
    while (!(if_valid && imem_ack) && n < 20) begin
      tick();
      n++;
    end
    chk("t4_precond", 32'(if_valid && imem_ack), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    redirect_valid = 1'b0;
    chk("t4_empty", 32'(if_valid), 32'd0);
    chk("t4_addr", 32'(imem_addr), 32'h20);
    chk("t4_pc", prog_count, 32'h80);
    repeat (4) tick();

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    chk("t5_addr_top", 32'(imem_addr), 32'hFF);
    chk("t5_pc_top", prog_count, 32'hFFFF_FFFC);
    tick();
    chk("t5_wrap_valid", 32'(if_valid), 32'd1);
    chk("t5_wrap_pc_plus4", if_pc_plus4, 32'h0);
    chk("t5_wrap_addr", 32'(imem_addr), 32'h0);
    repeat (3) tick();

    // asynchronous reset with a request in flight, stray acks ignored
    mem_lat = 2;
    n = 0;
    while (!(imem_req && lat_cnt == 1) && n < 20) begin
      tick();
      n++;
    end
    chk("t6_outstanding", 32'(imem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_req", 32'(imem_req), 32'd0);
    chk("t6_async_valid", 32'(if_valid), 32'd0);
    force_ack = 1'b1;
    tick();
    chk("t6_stray_ack_valid", 32'(if_valid), 32'd0);
    tick();
    mem_lat = 0;
    rst = 1'b0;
    load_stream(32'h0);
    tick();
    force_ack = 1'b0;
    chk("t6_idle_ack_ignored", 32'(if_valid), 32'd0);
    chk("t6_pc_restart", prog_count, 32'd0);
    repeat (5) tick();
    chk("t6_resumed", 32'(if_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
